// File: rtl/pipe_pkg.sv
// Shared defaults for the pipeline stage register slice.
package pipe_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int CTRL_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;
    localparam int MAX_DEPTH  = 4;
endpackage

// File: rtl/pipe_stage_cell.sv
// One pipeline slot: valid/ctrl/data with stall hold, flush and bubble zeroing.
module pipe_stage_cell
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (flush_i) begin
            // Data is left alone; only the bits that can cause side effects clear.
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (!stall_i) begin
            valid_d = valid_i;
            ctrl_d  = valid_i ? ctrl_i : '0;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// DEPTH-deep pipeline register chain with stall/flush and saturating event counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              cnt_clr_i,
    input  logic              valid_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
        $fatal(1, "pipe_stage_reg: DEPTH %0d outside 1..%0d", DEPTH, MAX_DEPTH);
    end

    // Index 0 is the upstream input; index k+1 is the output of cell k.
    logic [DEPTH:0]    vld;
    logic [CTRL_W-1:0] ctl [DEPTH+1];
    logic [DATA_W-1:0] dat [DEPTH+1];

    assign vld[0] = valid_in;
    assign ctl[0] = ctrl_in;
    assign dat[0] = data_in;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        pipe_stage_cell #(
            .DATA_W (DATA_W),
            .CTRL_W (CTRL_W)
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .stall_i (stall_i),
            .flush_i (flush_i),
            .valid_i (vld[k]),
            .ctrl_i  (ctl[k]),
            .data_i  (dat[k]),
            .valid_o (vld[k+1]),
            .ctrl_o  (ctl[k+1]),
            .data_o  (dat[k+1])
        );
    end

    assign valid_out = vld[DEPTH];
    assign ctrl_out  = ctl[DEPTH];
    assign data_out  = dat[DEPTH];

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr_i) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_i && !flush_i && stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (flush_i && flush_cnt_q != '1) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a DEPTH=3/CNT_W=4 and a DEPTH=1 instance vs a slot model.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        cnt_clr_i = 1'b0;
    logic        valid_in = 1'b0;
    logic [7:0]  ctrl_in = '0;
    logic [31:0] data_in = '0;

    logic        v3, v1;
    logic [7:0]  c3, c1;
    logic [31:0] d3, d1;
    logic [3:0]  sc3, fc3;
    logic [15:0] sc1, fc1;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .DEPTH(3), .CNT_W(4)) u3 (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .cnt_clr_i(cnt_clr_i), .valid_in(valid_in), .ctrl_in(ctrl_in),
        .data_in(data_in), .valid_out(v3), .ctrl_out(c3), .data_out(d3),
        .stall_cnt(sc3), .flush_cnt(fc3)
    );

    pipe_stage_reg #(.DEPTH(1)) u1 (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .cnt_clr_i(cnt_clr_i), .valid_in(valid_in), .ctrl_in(ctrl_in),
        .data_in(data_in), .valid_out(v1), .ctrl_out(c1), .data_out(d1),
        .stall_cnt(sc1), .flush_cnt(fc1)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        v;
        bit [7:0]  c;
        bit [31:0] d;
    } tok_t;

    tok_t m3 [$];
    tok_t m1 [$];
    int   ms3, mf3, ms1, mf1;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v < mx) ? v + 1 : mx;
    endfunction

    task automatic m_reset();
        tok_t z;
        z = '{v: 1'b0, c: 8'h0, d: 32'h0};
        m3 = {z, z, z};
        m1 = {z};
        ms3 = 0; mf3 = 0; ms1 = 0; mf1 = 0;
    endtask

    // Slots are listed newest first; the last entry is what the outputs show.
    task automatic m_edge();
        tok_t t;
        if (cnt_clr_i) begin
            ms3 = 0; mf3 = 0; ms1 = 0; mf1 = 0;
        end else begin
            if (stall_i && !flush_i) begin
                ms3 = sat(ms3, 15);
                ms1 = sat(ms1, 65535);
            end
            if (flush_i) begin
                mf3 = sat(mf3, 15);
                mf1 = sat(mf1, 65535);
            end
        end
        if (flush_i) begin
            foreach (m3[i]) begin m3[i].v = 0; m3[i].c = 0; end
            foreach (m1[i]) begin m1[i].v = 0; m1[i].c = 0; end
        end else if (!stall_i) begin
            t.v = valid_in;
            t.c = valid_in ? ctrl_in : 8'h0;
            t.d = data_in;
            m3.push_front(t);
            void'(m3.pop_back());
            m1.push_front(t);
            void'(m1.pop_back());
        end
    endtask

    task automatic cmp_all();
        chk("v3", 64'(v3), 64'(m3[2].v));
        chk("c3", 64'(c3), 64'(m3[2].c));
        chk("d3", 64'(d3), 64'(m3[2].d));
        chk("sc3", 64'(sc3), 64'(ms3));
        chk("fc3", 64'(fc3), 64'(mf3));
        chk("v1", 64'(v1), 64'(m1[0].v));
        chk("c1", 64'(c1), 64'(m1[0].c));
        chk("d1", 64'(d1), 64'(m1[0].d));
        chk("sc1", 64'(sc1), 64'(ms1));
        chk("fc1", 64'(fc1), 64'(mf1));
    endtask

    task automatic step();
        @(posedge clk);
        m_edge();
        #1;
        cmp_all();
    endtask

    task automatic drive(input bit v, input bit [7:0] c, input bit [31:0] d,
                         input bit st, input bit fl, input bit cl);
        valid_in = v; ctrl_in = c; data_in = d;
        stall_i = st; flush_i = fl; cnt_clr_i = cl;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_v3"}, 64'(v3), 64'd0);
        chk({tag, "_c3"}, 64'(c3), 64'd0);
        chk({tag, "_d3"}, 64'(d3), 64'd0);
        chk({tag, "_sc3"}, 64'(sc3), 64'd0);
        chk({tag, "_fc3"}, 64'(fc3), 64'd0);
        chk({tag, "_v1"}, 64'(v1), 64'd0);
        chk({tag, "_d1"}, 64'(d1), 64'd0);
        chk({tag, "_sc1"}, 64'(sc1), 64'd0);
    endtask

    initial begin
        int    emerge [$];
        int    got [$];
        int    tok, s0, f0;
        bit    st;
        m_reset();
        #3;
        chk_zero("rst");
        #4 rst = 1'b0;

        // Single-cycle latency on the DEPTH=1 instance.
        drive(1, 8'hA5, 32'h1234_5678, 0, 0, 0);
        step();
        chk("d1lat_v", 64'(v1), 64'd1);
        chk("d1lat_c", 64'(c1), 64'hA5);
        chk("d1lat_d", 64'(d1), 64'h1234_5678);

        // Token stream with stalls on cycles 2-3; upstream holds while stalled.
        drive(0, 0, 0, 0, 0, 1);
        step();
        step();
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step();
        s0 = int'(sc3);
        tok = 0;
        for (int c = 0; c < 20; c++) begin
            st = (c == 2 || c == 3);
            if (tok < 6) drive(1, 8'(8'h10 + tok), 32'(100 + tok), st, 0, 0);
            else drive(0, 8'hFF, 32'h0, st, 0, 0);
            step();
            if (!st && tok < 6) tok++;
            if (v3) begin
                got.push_back(int'(d3));
                emerge.push_back(c + 1);
            end
        end
        chk("stream_cnt", 64'(got.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            chk("stream_ord", 64'(got.size() > i ? got[i] : -1), 64'(100 + i));
            chk("stream_lat", 64'(emerge.size() > i ? emerge[i] : -1),
                64'(5 + i));
        end
        chk("stream_stall", 64'(int'(sc3) - s0), 64'd2);

        // Flush beats stall with three valid tokens in flight.
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'h3C, 32'(200 + i), 0, 0, 0);
            step();
        end
        chk("fill_v", 64'(v3), 64'd1);
        s0 = int'(sc3);
        f0 = int'(fc3);
        drive(1, 8'h3C, 32'h0, 1, 1, 0);
        step();
        chk("flush_v", 64'(v3), 64'd0);
        chk("flush_c", 64'(c3), 64'd0);
        chk("flush_fc", 64'(int'(fc3) - f0), 64'd1);
        chk("flush_sc", 64'(sc3), 64'(s0));
        drive(0, 8'h00, 32'h0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("flush_empty", 64'(v3), 64'd0);
        end

        // Bubble with dirty ctrl must reach the outputs with ctrl zeroed.
        drive(0, 8'hFF, 32'hDEAD_BEEF, 0, 0, 0);
        step();
        chk("bub1_c", 64'(c1), 64'd0);
        drive(1, 8'h11, 32'h1, 0, 0, 0);
        step();
        step();
        chk("bub3_v", 64'(v3), 64'd0);
        chk("bub3_c", 64'(c3), 64'd0);
        chk("bub3_d", 64'(d3), 64'hDEAD_BEEF);

        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), $urandom,
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 15) == 0));
            step();
        end

        // Saturation and clear-over-increment on the 4-bit counter.
        drive(0, 0, 0, 0, 0, 1);
        step();
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 1, 0, 0);
            step();
        end
        chk("sat_sc3", 64'(sc3), 64'hF);
        chk("sat_sc1", 64'(sc1), 64'd20);
        drive(0, 0, 0, 1, 0, 1);
        step();
        chk("clr_sc3", 64'(sc3), 64'd0);

        // Asynchronous reset between edges with tokens in flight.
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'h77, 32'(300 + i), i == 0, 0, 0);
            step();
        end
        chk("pre_rst_v", 64'(v1), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk_zero("arst");
        m_reset();
        #1 rst = 1'b0;
        drive(1, 8'h55, 32'h0BAD_F00D, 0, 0, 0);
        for (int i = 0; i < 3; i++) step();
        chk("post_rst_v", 64'(v3), 64'd1);
        chk("post_rst_d", 64'(d3), 64'h0BAD_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
